// File: rtl/bus_copy_initiator.sv
// Word-granular memory-to-memory copy engine, initiator side of the request/ready bus.
// Each word is a read handshake followed by a write handshake; every wait is bounded by TIMEOUT.
//
// state  | meaning
// IDLE   | waiting for i_start
// RD     | read request high, waiting for ready
// RD_REL | request low, waiting for ready to drop
// WR     | write request high, waiting for ready
// WR_REL | request low, waiting for ready to drop, then advance
// FIN    | one-cycle done pulse
module bus_copy_initiator #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_src,
    input  logic [31:0] i_dst,
    input  logic [31:0] i_count,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_words,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready
);

    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD, RD_REL, WR, WR_REL, FIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_timer;
    logic [31:0]   r_src;
    logic [31:0]   r_dst;
    logic [31:0]   r_count;
    logic [31:0]   r_words;
    logic [31:0]   r_data;
    logic [31:0]   r_bus_address;
    logic          r_bus_request;
    logic          r_bus_rw;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          r_pend;
    logic          w_tmo;
    logic          w_last;
    logic          w_stop;
    logic          w_err_set;

    assign w_tmo  = (r_timer == '0);
    assign w_last = ((r_words + 32'd1) == r_count);
    assign w_stop = w_last | r_pend | i_abort;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In RD a low request means the entry check (count 0 or abort at start) chose to skip the bus.
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) w_next = RD;
            end
            RD: begin
                if (!r_bus_request) begin
                    w_next = FIN;
                end else if (i_bus_ready) begin
                    w_next = RD_REL;
                end else if (w_tmo) begin
                    w_next    = FIN;
                    w_err_set = 1'b1;
                end
            end
            RD_REL: begin
                if (!i_bus_ready) begin
                    w_next = WR;
                end else if (w_tmo) begin
                    w_next    = FIN;
                    w_err_set = 1'b1;
                end
            end
            WR: begin
                if (i_bus_ready) begin
                    w_next = WR_REL;
                end else if (w_tmo) begin
                    w_next    = FIN;
                    w_err_set = 1'b1;
                end
            end
            WR_REL: begin
                if (!i_bus_ready) begin
                    w_next = w_stop ? FIN : RD;
                end else if (w_tmo) begin
                    w_next    = FIN;
                    w_err_set = 1'b1;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timer       <= '0;
            r_src         <= '0;
            r_dst         <= '0;
            r_count       <= '0;
            r_words       <= '0;
            r_data        <= '0;
            r_bus_address <= '0;
            r_bus_request <= 1'b0;
            r_bus_rw      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_pend        <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == FIN);

            if (w_next != r_state) begin
                r_timer <= TMO_LOAD;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - TW'(1);
            end

            if (r_state == IDLE) begin
                r_pend <= i_start & i_abort;
            end else begin
                r_pend <= r_pend | i_abort;
            end

            if (w_err_set) r_error <= 1'b1;

            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_src         <= i_src;
                        r_dst         <= i_dst;
                        r_count       <= i_count;
                        r_words       <= '0;
                        r_error       <= 1'b0;
                        r_bus_address <= i_src;
                        r_bus_rw      <= 1'b0;
                        r_bus_request <= (i_count != 32'd0) & ~i_abort;
                    end
                end
                RD: begin
                    if (r_bus_request && i_bus_ready) r_data <= i_bus_rdata;
                    if (w_next != RD) r_bus_request <= 1'b0;
                end
                RD_REL: begin
                    if (w_next == WR) begin
                        r_bus_request <= 1'b1;
                        r_bus_rw      <= 1'b1;
                        r_bus_address <= r_dst;
                    end
                end
                WR: begin
                    if (w_next != WR) r_bus_request <= 1'b0;
                end
                WR_REL: begin
                    if (!i_bus_ready) begin
                        r_src   <= r_src + 32'd4;
                        r_dst   <= r_dst + 32'd4;
                        r_words <= r_words + 32'd1;
                        if (w_next == RD) begin
                            r_bus_request <= 1'b1;
                            r_bus_rw      <= 1'b0;
                            r_bus_address <= r_src + 32'd4;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_words       = r_words;
    assign o_bus_request = r_bus_request;
    assign o_bus_rw      = r_bus_rw;
    assign o_bus_address = r_bus_address;
    assign o_bus_wdata   = r_data;

endmodule

// File: tb/tb_bus_copy_initiator.sv
// Bench for bus_copy_initiator: table of copy jobs against a request/ready responder model,
// with a scoreboard of expected bus accesses and hand-written timeout and reset/wrap sequences.
module tb_bus_copy_initiator;

    logic        i_clock;
    logic        i_reset_n;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_src;
    logic [31:0] i_dst;
    logic [31:0] i_count;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_words;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ready;

    bus_copy_initiator #(.TIMEOUT(16)) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_src         (i_src),
        .i_dst         (i_dst),
        .i_count       (i_count),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_words       (o_words),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_rdata   (i_bus_rdata),
        .i_bus_ready   (i_bus_ready)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] q_rd [$];
    logic [63:0] q_wr [$];

    int lat_cfg    = 0;
    bit hang_write = 1'b0;
    int rsp_cnt;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] count;
        int          lat;
        int          abort_rd;
        bit          start_busy;
        int          exp_words;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Responder: ready after lat_cfg extra cycles, held until request drops.
    always @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            i_bus_ready <= 1'b0;
            i_bus_rdata <= 32'd0;
            rsp_cnt     <= 0;
        end else if (!o_bus_request) begin
            i_bus_ready <= 1'b0;
            rsp_cnt     <= 0;
        end else if (!i_bus_ready) begin
            if (rsp_cnt < lat_cfg) begin
                rsp_cnt <= rsp_cnt + 1;
            end else if (!(o_bus_rw && hang_write)) begin
                i_bus_ready <= 1'b1;
                if (!o_bus_rw) i_bus_rdata <= rdata_of(o_bus_address);
            end
        end
    end

    // Monitor: stability while request is high, scoreboard pop on each handshake.
    logic        mon_prev_req = 1'b0;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_rw;
    logic [63:0] wr_exp;
    always @(negedge i_clock) begin
        if (i_reset_n && o_bus_request) begin
            if (!mon_prev_req) begin
                cap_addr  = o_bus_address;
                cap_wdata = o_bus_wdata;
                cap_rw    = o_bus_rw;
            end else begin
                check("stable_addr", o_bus_address, cap_addr);
                check("stable_rw", {31'd0, o_bus_rw}, {31'd0, cap_rw});
                if (o_bus_rw) check("stable_wdata", o_bus_wdata, cap_wdata);
            end
            if (i_bus_ready) begin
                if (!o_bus_rw) begin
                    if (q_rd.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL rd_unexpected: got read at 0x%08h, want no access", o_bus_address);
                    end else begin
                        check("rd_addr", o_bus_address, q_rd.pop_front());
                    end
                end else begin
                    if (q_wr.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL wr_unexpected: got write at 0x%08h, want no access", o_bus_address);
                    end else begin
                        wr_exp = q_wr.pop_front();
                        check("wr_addr", o_bus_address, wr_exp[63:32]);
                        check("wr_data", o_bus_wdata, wr_exp[31:0]);
                    end
                end
            end
        end
        mon_prev_req = o_bus_request;
    end

    task automatic run_copy(input vec_t v);
        int   cyc;
        int   rises;
        int   rd_rises;
        logic prev;
        bit   aborted;
        lat_cfg = v.lat;
        for (int i = 0; i < v.exp_words; i++) begin
            q_rd.push_back(v.src + 32'(4 * i));
            q_wr.push_back({v.dst + 32'(4 * i), rdata_of(v.src + 32'(4 * i))});
        end
        @(negedge i_clock);
        i_src   = v.src;
        i_dst   = v.dst;
        i_count = v.count;
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        cyc = 1;
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
        check("error_cleared", {31'd0, o_error}, 32'd0);
        rises = 0; rd_rises = 0; prev = 1'b0; aborted = 1'b0;
        while (1) begin
            if (o_bus_request && !prev) begin
                rises++;
                if (!o_bus_rw) rd_rises++;
            end
            prev    = o_bus_request;
            i_abort = 1'b0;
            if (v.abort_rd != 0 && !aborted && o_bus_request && !o_bus_rw && rd_rises == v.abort_rd) begin
                i_abort = 1'b1;
                aborted = 1'b1;
            end
            if (v.start_busy && cyc == 5) begin
                i_start = 1'b1;
                i_src   = 32'hDEAD_0000;
                i_count = 32'd7;
            end else begin
                i_start = 1'b0;
            end
            if (o_done || cyc >= 3000) break;
            @(negedge i_clock);
            cyc++;
        end
        i_abort = 1'b0;
        i_start = 1'b0;
        if (!o_done) begin
            n_cmp++; n_fail++;
            $display("FAIL done_wait: got no o_done in %0d cycles, want done at %0d", cyc, v.exp_done);
        end else begin
            check("done_cycle", 32'(cyc), 32'(v.exp_done));
            check("busy_at_done", {31'd0, o_busy}, 32'd1);
            check("words", o_words, 32'(v.exp_words));
            check("error", {31'd0, o_error}, 32'd0);
        end
        check("req_rises", 32'(rises), 32'(2 * v.exp_words));
        @(negedge i_clock);
        check("busy_after_done", {31'd0, o_busy}, 32'd0);
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
        check("req_idle", {31'd0, o_bus_request}, 32'd0);
        check("rd_left", 32'(q_rd.size()), 32'd0);
        check("wr_left", 32'(q_wr.size()), 32'd0);
        q_rd.delete();
        q_wr.delete();
    endtask

    initial begin
        int   cyc;
        int   wr_cyc;
        vec_t vz;
        vec_t vw;

        mem[32'h100] = 32'hA;
        mem[32'h104] = 32'hB;
        mem[32'h108] = 32'hC;

        vecs[0] = '{32'h100,  32'h200,  32'd3, 0, 0, 1'b0, 3, 25};
        vecs[1] = '{32'h180,  32'h280,  32'd0, 0, 0, 1'b0, 0, 2};
        vecs[2] = '{32'h1000, 32'h2000, 32'd1, 0, 0, 1'b0, 1, 9};
        vecs[3] = '{32'h400,  32'h800,  32'd5, 0, 2, 1'b0, 2, 17};
        vecs[4] = '{32'h600,  32'h700,  32'd3, 4, 0, 1'b1, 3, 49};
        vecs[5] = '{32'h3000, 32'h3100, 32'd2, 1, 0, 1'b0, 2, 21};

        i_reset_n = 1'b1;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_src     = 32'd0;
        i_dst     = 32'd0;
        i_count   = 32'd0;
        #1 i_reset_n = 1'b0;
        #2;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);
        check("rst_words", o_words, 32'd0);
        check("rst_req", {31'd0, o_bus_request}, 32'd0);
        check("rst_rw", {31'd0, o_bus_rw}, 32'd0);
        check("rst_addr", o_bus_address, 32'd0);
        check("rst_wdata", o_bus_wdata, 32'd0);
        repeat (3) @(negedge i_clock);
        i_reset_n = 1'b1;

        for (int k = 0; k < 6; k++) run_copy(vecs[k]);

        // Write never acknowledged: 16 cycles in WR, then error and done.
        hang_write = 1'b1;
        lat_cfg    = 0;
        q_rd.push_back(32'h500);
        @(negedge i_clock);
        i_src = 32'h500; i_dst = 32'h540; i_count = 32'd1; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        cyc = 1; wr_cyc = 0;
        while (!o_done && cyc < 200) begin
            if (o_bus_request && o_bus_rw) wr_cyc++;
            @(negedge i_clock);
            cyc++;
        end
        check("tmo_done_cycle", 32'(cyc), 32'd21);
        check("tmo_wr_cycles", 32'(wr_cyc), 32'd16);
        check("tmo_error", {31'd0, o_error}, 32'd1);
        check("tmo_words", o_words, 32'd0);
        check("tmo_req_low", {31'd0, o_bus_request}, 32'd0);
        @(negedge i_clock);
        check("tmo_idle", {31'd0, o_busy}, 32'd0);
        check("tmo_sticky", {31'd0, o_error}, 32'd1);
        check("tmo_rd_left", 32'(q_rd.size()), 32'd0);
        hang_write = 1'b0;
        vz = '{32'h0, 32'h0, 32'd0, 0, 0, 1'b0, 0, 2};
        run_copy(vz);

        // Asynchronous reset in the middle of a write request.
        lat_cfg = 4;
        q_rd.push_back(32'h100);
        @(negedge i_clock);
        i_src = 32'h100; i_dst = 32'h900; i_count = 32'd3; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        cyc = 0;
        while (!(o_bus_request && o_bus_rw) && cyc < 200) begin
            @(negedge i_clock);
            cyc++;
        end
        check("reached_wr", {31'd0, o_bus_request & o_bus_rw}, 32'd1);
        #1 i_reset_n = 1'b0;
        #1;
        check("arst_req", {31'd0, o_bus_request}, 32'd0);
        check("arst_busy", {31'd0, o_busy}, 32'd0);
        check("arst_done", {31'd0, o_done}, 32'd0);
        check("arst_rd_left", 32'(q_rd.size()), 32'd0);
        q_wr.delete();
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        vw = '{32'hFFFF_FFFC, 32'h300, 32'd2, 0, 0, 1'b0, 2, 17};
        run_copy(vw);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_copy_initiator.md
# bus_copy_initiator

Word-granular memory-to-memory copy engine acting as the initiating end of the peripheral request/ready bus. On a start pulse it reads a word from a source address and writes it to a destination address, repeating for a programmed word count. It honours the responder-side rules: one access per rising edge of request, and ready is held until request drops. It sits between a control source (CPU-side register block or sequencer) and the peripheral/memory interconnect, and reports completion, progress, and per-access timeout errors.

## Interface
- TIMEOUT, 1024: cycles to wait for each ready edge before aborting with error; minimum 2.
- i_clock  in  1  sole clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle start pulse; ignored while o_busy.
- i_abort  in  1  request early stop; level, sampled each cycle.
- i_src  in  32  source byte address, captured on accepted start.
- i_dst  in  32  destination byte address, captured on accepted start.
- i_count  in  32  number of 32-bit words, captured on accepted start.
- o_busy  out  1  high from cycle after accepted start until o_done cycle inclusive.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  sticky timeout flag; cleared on next accepted start.
- o_words  out  32  words fully written so far in current/last transfer.
- o_bus_request  out  1  bus request.
- o_bus_rw  out  1  0 = read, 1 = write.
- o_bus_address  out  32  byte address.
- o_bus_wdata  out  32  write data.
- i_bus_rdata  in  32  read data, valid while i_bus_ready high on a read.
- i_bus_ready  in  1  responder acknowledge.

## Operation
- Reset (asynchronous assertion): all outputs 0, state IDLE, internal registers 0. Outputs are 0 immediately on i_reset_n low, mid-transfer included. No bus cleanup is attempted.
- States: IDLE, RD, RD_REL, WR, WR_REL, FIN.
- IDLE: on i_start go to RD. Capture src, dst, and count. Clear o_error and o_words. If count == 0, go to FIN with no bus activity.
- RD: o_bus_request=1, o_bus_rw=0, o_bus_address=src. On i_bus_ready=1, latch i_bus_rdata into the data register and go to RD_REL.
- RD_REL: request=0. Wait for i_bus_ready=0, then go to WR.
- WR: request=1, rw=1, address=dst, wdata=latched data. On ready, go to WR_REL.
- WR_REL: request=0. On ready low:
  - src+=4, dst+=4, o_words+=1.
  - If o_words (new) == count or abort pending, go to FIN; else go to RD.
- FIN: o_done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^32; wrap past 0xFFFFFFFC is silent.
- Address, rw, and wdata stay stable for the entire time request is high.
- Abort: i_abort high in any cycle while busy sets an internal pending flag. It is honoured only in WR_REL exit or at RD entry, so no handshake is ever truncated. No error is raised. Pending is cleared in IDLE.
- Timeout: a counter is reset on every state entry and counts cycles in RD, WR, RD_REL, and WR_REL. Reaching TIMEOUT sets o_error, drops request, and goes to FIN. o_words reflects completed writes only.
- Simultaneous i_start and i_abort in IDLE: start is accepted and abort is pending. The first RD entry then finishes with o_words=0 and no bus access.

## Timing
- All outputs are registered.
- Start accepted at edge E: o_busy=1 and request=1 (RD) in the cycle after E.
- With a one-cycle responder (ready registered from request rising edge), each access takes 4 cycles:
  - request high 2 cycles, then low;
  - ready seen low one cycle later;
  - next request follows the next cycle.
- One word = 8 cycles. N words: o_done is asserted 8N+1 cycles after start edge. Count 0: o_done is asserted 2 cycles after start edge.
- Request is low for at least 2 consecutive cycles between accesses, guaranteeing the responder sees a fresh rising edge.
- o_done and o_busy drop together after the FIN cycle. A new start is accepted in the cycle following FIN.

## Test plan
- Copy 3 words, src=0x100 (data 0xA,0xB,0xC), dst=0x200, one-cycle responder: writes appear at 0x200/0x204/0x208 with 0xA/0xB/0xC; o_words=3; o_done 25 cycles after start; o_error=0.
- i_count=0: no o_bus_request ever high; o_done pulse 2 cycles after start; o_words=0.
- Responder never asserts ready on the write, TIMEOUT=16: o_error=1 after 16 cycles in WR; request drops; o_done pulses; o_words=0. The next start clears o_error.
- i_abort pulsed during the 2nd read of a 5-word copy: that read and its write complete; o_done follows with o_words=2; bus is idle afterwards.
- i_reset_n low mid-WR with request high: request, busy, and done are 0 immediately, before the next clock edge. After release, i_start with i_src=0xFFFFFFFC and i_count=2 reads 0xFFFFFFFC then 0x00000000 (wrap).
- Slow responder (ready 5 cycles after request) plus i_start pulsed while busy: the extra start is ignored; address/wdata are stable throughout each request; the transfer completes correctly.
